// File: rtl/adder_pkg.sv
// Shared constants for the datapath adder family.
package adder_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 64;
endpackage

// File: rtl/full_adder_1bit.sv
// One ripple-carry cell: sum and carry for a single bit position.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_64.sv
// Unsigned WIDTH-bit ripple adder {CarryOut, Sum} = X + Y + CarryIn, optionally registered.
module full_adder_64
    import adder_pkg::*;
#(
    parameter int WIDTH   = ADDER_WIDTH_DEFAULT,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CarryIn,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;

    assign c[0] = CarryIn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_fa (
            .a   (X[i]),
            .b   (Y[i]),
            .cin (c[i]),
            .s   (sum_d[i]),
            .cout(c[i+1])
        );
    end

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;

        // Reset clears the outputs at once and drops whatever result was in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= c[WIDTH];
            end
        end

        assign Sum      = sum_q;
        assign CarryOut = cout_q;
    end else begin : g_comb
        assign Sum      = sum_d;
        assign CarryOut = c[WIDTH];
    end
endmodule

// File: tb/tb_full_adder_64.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks each registered output.
module tb_full_adder_64;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] X, Y, Sum;
    logic        CarryIn, CarryOut;
    logic [7:0]  x8, y8, s8;
    logic        ci8, co8;

    always #5 clk = ~clk;

    full_adder_64 #(.WIDTH(64), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .CarryIn(CarryIn),
        .Sum(Sum), .CarryOut(CarryOut)
    );

    // Narrow combinational instance; reset held low to show it is ignored.
    full_adder_64 #(.WIDTH(8), .OUT_REG(1'b0)) dut_c (
        .clk(clk), .rst_n(1'b0), .X(x8), .Y(y8), .CarryIn(ci8),
        .Sum(s8), .CarryOut(co8)
    );

    typedef struct {
        logic [64:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check65(input string tag, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic apply(input logic [63:0] x, input logic [63:0] y, input logic ci,
                         input logic [64:0] exp, input string tag);
        @(negedge clk);
        X = x; Y = y; CarryIn = ci;
        sb.push_back('{exp: exp, tag: tag});
    endtask

    task automatic comb(input logic [7:0] x, input logic [7:0] y, input logic ci,
                        input logic [8:0] exp, input string tag);
        x8 = x; y8 = y; ci8 = ci;
        #1;
        check65(tag, {56'd0, co8, s8}, {56'd0, exp});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check65(e.tag, {CarryOut, Sum}, e.exp);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] rx, ry;
        logic        rc;
        rst_n = 1'b0; X = 64'd5; Y = 64'd7; CarryIn = 1'b0;
        x8 = '0; y8 = '0; ci8 = 1'b0;
        #1;
        check65("reset_state", {CarryOut, Sum}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(64'd1, 64'd1, 1'b0, 65'd2, "1+1");
        apply(64'd200, 64'd400, 1'b0, 65'd600, "200+400");
        apply(64'd9999999, 64'd1, 1'b1, 65'd10000001, "9999999+1+1");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0}, "ones+0+1");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, "ones+ones+1");
        apply(64'd0, 64'd0, 1'b0, 65'd0, "0+0+0");
        apply(64'd5, 64'd7, 1'b0, 65'd12, "5+7_pre_reset");

        // Pulse reset between edges with the operands held.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check65("async_reset_clears", {CarryOut, Sum}, 65'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check65("zero_until_edge", {CarryOut, Sum}, 65'd0);
        sb.push_back('{exp: 65'd12, tag: "5+7_post_reset"});

        apply(64'd3, 64'd4, 1'b0, 65'd7, "3+4");
        apply(64'd10, 64'd20, 1'b1, 65'd31, "10+20+1");

        for (int i = 0; i < 1000; i++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            apply(rx, ry, rc, {1'b0, rx} + {1'b0, ry} + {64'd0, rc}, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end

        comb(8'hFF, 8'h00, 1'b1, 9'h100, "comb_ones+0+1");
        comb(8'h00, 8'h00, 1'b0, 9'h000, "comb_0+0+0");
        comb(8'd200, 8'd100, 1'b0, 9'd300, "comb_200+100");
        comb(8'hFF, 8'hFF, 1'b1, 9'h1FF, "comb_max");
        comb(8'h0F, 8'h01, 1'b0, 9'h010, "comb_0f+1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
